inference_sequencer: RTL and testbench
======================================

INFERENCE_SEQUENCER -- requirements
Module: inference_sequencer

Interface
REQ-001 Parameter ADDR_W, default 8: sample-memory address width.
REQ-002 Parameter IN_W, default 16: sample word width, equal to the model input width.
REQ-003 Parameter OUT_W, default 8: prediction width, equal to the model output width.
REQ-004 Parameter MODEL_LAT, default 2: cycles from model_sample change to a valid model_pred (0 allowed).
REQ-005 clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 start  input  1  begin a run at address 0; honoured only in IDLE or DONE.
REQ-008 mem_addr  output  ADDR_W  registered sample-memory read address.
REQ-009 mem_rdata  input  IN_W  memory data, valid one cycle after mem_addr is presented.
REQ-010 model_sample  output  IN_W  registered sample presented to the model.
REQ-011 model_pred  input  OUT_W  model prediction.
REQ-012 pred_out  output  OUT_W  captured prediction.
REQ-013 pred_valid  output  1  pred_out valid; held until accepted.
REQ-014 pred_ready  input  1  downstream accepts pred_out when pred_valid=1.
REQ-015 busy  output  1  high in any state other than IDLE or DONE.
REQ-016 done  output  1  run finished; held until start or rst.
REQ-017 overflow  output  1  run ended by address wrap rather than by the sentinel.
REQ-018 sample_count  output  ADDR_W+1  number of predictions accepted in the current run.

Function
REQ-019 FSM states: IDLE, READ, CHECK, COMPUTE, OUTPUT, DONE.
REQ-020 IDLE/DONE + start: clear mem_addr, sample_count, done and overflow; go to READ.
REQ-021 READ: lasts 1 cycle while mem_addr is stable; go to CHECK.
REQ-022 CHECK: mem_rdata all-ones (sentinel) -> DONE with done=1 and overflow=0; otherwise load model_sample with mem_rdata, load the latency counter with MODEL_LAT, go to COMPUTE.
REQ-023 COMPUTE: lasts exactly MODEL_LAT+1 cycles; in its final cycle, capture model_pred into pred_out and go to OUTPUT.
REQ-024 OUTPUT: pred_valid=1; pred_out and pred_valid are held stable while pred_ready=0.
REQ-025 OUTPUT with pred_ready=1: increment sample_count; if mem_addr = 2^ADDR_W-1, go to DONE with done=1 and overflow=1; otherwise increment mem_addr and go to READ.
REQ-026 Per-sample cycle count with pred_ready held at 1: MODEL_LAT+4.
REQ-027 start is ignored while busy=1.
REQ-028 The sentinel word is never forwarded to the model and is never counted.
REQ-029 model_sample holds its last value outside CHECK loads.

Reset
REQ-030 rst=1 at any clock edge, including mid-run: state becomes IDLE; mem_addr, model_sample, pred_out and sample_count become 0; pred_valid, busy, done and overflow become 0.
REQ-031 rst has priority over start and pred_ready in the same cycle.

Configuration
REQ-032 Macro INF_SEQ_CYCLE_CNT_EN defined: add output cycle_count (32 bits), which clears on rst or on an accepted start, increments every cycle busy=1, saturates at all-ones, and holds its value in DONE.
REQ-033 Macro INF_SEQ_CYCLE_CNT_EN undefined: no cycle_count port and no counter logic; all other behaviour is identical.

Verification
REQ-034 MODEL_LAT=2, memory {5,7,FFFF}, pred_ready=1, pulse start -> two pred_valid pulses 6 cycles apart; done=1, overflow=0, sample_count=2.
REQ-035 Sentinel at address 0, pulse start -> no pred_valid; done=1 two cycles after busy rises; sample_count=0.
REQ-036 pred_ready held at 0 for 10 cycles in OUTPUT -> pred_out is stable and pred_valid=1 for all 10 cycles; one count is added on acceptance.
REQ-037 ADDR_W=2, no sentinel in memory -> 4 predictions accepted, then done=1, overflow=1, sample_count=4.
REQ-038 rst asserted during COMPUTE of sample 1 -> all outputs are 0 on the next cycle; a fresh start begins again at address 0.
REQ-039 MODEL_LAT=0 with INF_SEQ_CYCLE_CNT_EN defined and memory {3,FFFF} -> pred_out is captured one cycle after CHECK; cycle_count=6 when done rises.

Source files
------------

// File: rtl/inference_sequencer.sv
// Sequencer that streams samples from memory through an inference model until a sentinel or address wrap.
// Optional build macro INF_SEQ_CYCLE_CNT_EN adds a saturating busy-cycle counter output (cycle_count).
module inference_sequencer #(
  parameter int ADDR_W    = 8,
  parameter int IN_W      = 16,
  parameter int OUT_W     = 8,
  parameter int MODEL_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [IN_W-1:0]   mem_rdata,
  output logic [IN_W-1:0]   model_sample,
  input  logic [OUT_W-1:0]  model_pred,
  output logic [OUT_W-1:0]  pred_out,
  output logic              pred_valid,
  input  logic              pred_ready,
  output logic              busy,
  output logic              done,
  output logic              overflow,
  output logic [ADDR_W:0]   sample_count
`ifdef INF_SEQ_CYCLE_CNT_EN
  ,
  output logic [31:0]       cycle_count
`endif
);

  // state   | meaning
  // IDLE    | waiting for start after reset
  // READ    | address presented, memory data in flight
  // CHECK   | sentinel test, load model input
  // COMPUTE | wait out model latency, capture prediction on last cycle
  // OUTPUT  | prediction offered downstream until accepted
  // DONE    | run finished, results held until start
  typedef enum logic [2:0] {
    IDLE, READ, CHECK, COMPUTE, OUTPUT, DONE
  } state_t;

  localparam int LAT_W = (MODEL_LAT > 0) ? $clog2(MODEL_LAT + 1) : 1;

  state_t             state, state_nxt;
  logic [LAT_W-1:0]   lat_cnt;
  logic               ld_start, ld_sample, cap_pred, accept, wrap;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ld_start  = 1'b0;
    ld_sample = 1'b0;
    cap_pred  = 1'b0;
    accept    = 1'b0;
    wrap      = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          ld_start  = 1'b1;
          state_nxt = READ;
        end
      end
      READ: state_nxt = CHECK;
      CHECK: begin
        if (&mem_rdata) begin
          state_nxt = DONE;
        end else begin
          ld_sample = 1'b1;
          state_nxt = COMPUTE;
        end
      end
      COMPUTE: begin
        if (lat_cnt == '0) begin
          cap_pred  = 1'b1;
          state_nxt = OUTPUT;
        end
      end
      OUTPUT: begin
        if (pred_ready) begin
          accept = 1'b1;
          if (&mem_addr) begin
            wrap      = 1'b1;
            state_nxt = DONE;
          end else begin
            state_nxt = READ;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_addr     <= '0;
      model_sample <= '0;
      pred_out     <= '0;
      sample_count <= '0;
      overflow     <= 1'b0;
      lat_cnt      <= '0;
    end else begin
      if (ld_start) begin
        mem_addr     <= '0;
        sample_count <= '0;
        overflow     <= 1'b0;
      end
      if (ld_sample) begin
        model_sample <= mem_rdata;
        lat_cnt      <= LAT_W'(MODEL_LAT);
      end else if (state == COMPUTE && lat_cnt != '0) begin
        lat_cnt <= lat_cnt - LAT_W'(1);
      end
      if (cap_pred) pred_out <= model_pred;
      if (accept) begin
        sample_count <= sample_count + {{ADDR_W{1'b0}}, 1'b1};
        // At the top address the run ends instead of wrapping back to 0
        if (wrap) overflow <= 1'b1;
        else      mem_addr <= mem_addr + ADDR_W'(1);
      end
    end
  end

  assign pred_valid = (state == OUTPUT);
  assign busy       = (state != IDLE) && (state != DONE);
  assign done       = (state == DONE);

`ifdef INF_SEQ_CYCLE_CNT_EN
  always_ff @(posedge clk) begin
    if (rst || ld_start)               cycle_count <= '0;
    else if (busy && !(&cycle_count))  cycle_count <= cycle_count + 32'd1;
  end
`endif

endmodule

// File: tb/tb_inference_sequencer.sv
// Scoreboard bench for inference_sequencer: one LAT=2 instance for the main runs, one LAT=0 instance
// for the zero-latency and optional cycle counter case; both use a 4-entry memory (ADDR_W=2).
module tb_inference_sequencer;
  localparam int AW = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          start_a = 1'b0, ready_a = 1'b1;
  logic [AW-1:0] addr_a;
  logic [15:0]   rdata_a = '0, ms_a;
  logic [7:0]    pred_a, pout_a;
  logic          valid_a, busy_a, done_a, ovf_a;
  logic [AW:0]   cnt_a;
  logic [15:0]   mem_a [4];

  logic          start_b = 1'b0, ready_b = 1'b1;
  logic [AW-1:0] addr_b;
  logic [15:0]   rdata_b = '0, ms_b;
  logic [7:0]    pred_b, pout_b;
  logic          valid_b, busy_b, done_b, ovf_b;
  logic [AW:0]   cnt_b;
  logic [15:0]   mem_b [4];
`ifdef INF_SEQ_CYCLE_CNT_EN
  logic [31:0]   cc_a, cc_b;
`endif

  logic [7:0] exp_a [$];
  logic [7:0] exp_b [$];
  int         acc_cyc [$];

  function automatic logic [7:0] model_f(input logic [15:0] x);
    return (x[7:0] * 8'd3) ^ 8'h5A;
  endfunction

  // memories with one cycle read latency; model A has a two-stage pipeline, model B is combinational
  logic [7:0] pa1 = '0, pa2 = '0;
  always @(posedge clk) begin
    rdata_a <= mem_a[addr_a];
    rdata_b <= mem_b[addr_b];
    pa1     <= model_f(ms_a);
    pa2     <= pa1;
  end
  assign pred_a = pa2;
  assign pred_b = model_f(ms_b);

  inference_sequencer #(.ADDR_W(AW), .IN_W(16), .OUT_W(8), .MODEL_LAT(2)) u_a (
    .clk(clk), .rst(rst), .start(start_a), .mem_addr(addr_a), .mem_rdata(rdata_a),
    .model_sample(ms_a), .model_pred(pred_a), .pred_out(pout_a), .pred_valid(valid_a),
    .pred_ready(ready_a), .busy(busy_a), .done(done_a), .overflow(ovf_a), .sample_count(cnt_a)
`ifdef INF_SEQ_CYCLE_CNT_EN
    , .cycle_count(cc_a)
`endif
  );

  inference_sequencer #(.ADDR_W(AW), .IN_W(16), .OUT_W(8), .MODEL_LAT(0)) u_b (
    .clk(clk), .rst(rst), .start(start_b), .mem_addr(addr_b), .mem_rdata(rdata_b),
    .model_sample(ms_b), .model_pred(pred_b), .pred_out(pout_b), .pred_valid(valid_b),
    .pred_ready(ready_b), .busy(busy_b), .done(done_b), .overflow(ovf_b), .sample_count(cnt_b)
`ifdef INF_SEQ_CYCLE_CNT_EN
    , .cycle_count(cc_b)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin : mon_a
    logic [7:0] e;
    if (!rst && valid_a && ready_a) begin
      if (exp_a.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL a_unexpected_pred: got %0h expected none", pout_a);
      end else begin
        e = exp_a.pop_front();
        chk("a_pred", 32'(pout_a), 32'(e));
      end
      acc_cyc.push_back(cyc);
    end
  end

  always @(negedge clk) begin : mon_b
    logic [7:0] e;
    if (!rst && valid_b && ready_b) begin
      if (exp_b.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL b_unexpected_pred: got %0h expected none", pout_b);
      end else begin
        e = exp_b.pop_front();
        chk("b_pred", 32'(pout_b), 32'(e));
      end
    end
  end

  task automatic pulse_a();
    @(negedge clk); start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
  endtask

  task automatic wait_done_a(input int max);
    int n = 0;
    while (!done_a && n < max) begin
      @(negedge clk);
      n++;
    end
    chk("a_done_wait", 32'(done_a), 32'd1);
  endtask

  task automatic chk_zero_a(input string tag);
    chk({tag, "_addr"},  32'(addr_a),  32'd0);
    chk({tag, "_ms"},    32'(ms_a),    32'd0);
    chk({tag, "_pout"},  32'(pout_a),  32'd0);
    chk({tag, "_valid"}, 32'(valid_a), 32'd0);
    chk({tag, "_busy"},  32'(busy_a),  32'd0);
    chk({tag, "_done"},  32'(done_a),  32'd0);
    chk({tag, "_ovf"},   32'(ovf_a),   32'd0);
    chk({tag, "_cnt"},   32'(cnt_a),   32'd0);
  endtask

  initial begin
    int n;
    mem_a = '{16'd0, 16'd0, 16'd0, 16'd0};
    mem_b = '{16'd0, 16'd0, 16'd0, 16'd0};
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_zero_a("rst");
    rst = 1'b0;

    // two samples then sentinel
    mem_a = '{16'd5, 16'd7, 16'hFFFF, 16'd0};
    exp_a.push_back(8'h55);
    exp_a.push_back(8'h4F);
    acc_cyc.delete();
    pulse_a();
    wait_done_a(60);
    chk("t2_ovf",  32'(ovf_a),  32'd0);
    chk("t2_cnt",  32'(cnt_a),  32'd2);
    chk("t2_ms",   32'(ms_a),   32'd7);
    chk("t2_addr", 32'(addr_a), 32'd2);
    chk("t2_busy", 32'(busy_a), 32'd0);
    chk("t2_accepts", 32'(acc_cyc.size()), 32'd2);
    if (acc_cyc.size() == 2) chk("t2_gap", 32'(acc_cyc[1] - acc_cyc[0]), 32'd6);

    // sentinel at address 0
    mem_a[0] = 16'hFFFF;
    acc_cyc.delete();
    pulse_a();
    chk("t3_busy", 32'(busy_a), 32'd1);
    chk("t3_done_clr", 32'(done_a), 32'd0);
    @(negedge clk);
    chk("t3_done_early", 32'(done_a), 32'd0);
    @(negedge clk);
    chk("t3_done", 32'(done_a), 32'd1);
    chk("t3_cnt",  32'(cnt_a),  32'd0);
    chk("t3_ovf",  32'(ovf_a),  32'd0);
    chk("t3_ms",   32'(ms_a),   32'd7);
    chk("t3_accepts", 32'(acc_cyc.size()), 32'd0);

    // backpressure held for 10 cycles
    mem_a = '{16'd9, 16'hFFFF, 16'd0, 16'd0};
    ready_a = 1'b0;
    exp_a.push_back(8'h41);
    pulse_a();
    n = 0;
    while (!valid_a && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("t4_valid_wait", 32'(valid_a), 32'd1);
    for (int i = 0; i < 10; i++) begin
      chk("t4_hold_valid", 32'(valid_a), 32'd1);
      chk("t4_hold_pout",  32'(pout_a),  32'h41);
      if (i < 9) @(negedge clk);
    end
    @(posedge clk);
    #1 ready_a = 1'b1;
    wait_done_a(30);
    chk("t4_cnt", 32'(cnt_a), 32'd1);

    // no sentinel: address wrap ends run; mid-run start ignored
    mem_a = '{16'd1, 16'd2, 16'd3, 16'd4};
    exp_a.push_back(8'h59);
    exp_a.push_back(8'h5C);
    exp_a.push_back(8'h53);
    exp_a.push_back(8'h56);
    acc_cyc.delete();
    pulse_a();
    repeat (3) @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    wait_done_a(80);
    chk("t5_ovf",  32'(ovf_a),  32'd1);
    chk("t5_cnt",  32'(cnt_a),  32'd4);
    chk("t5_addr", 32'(addr_a), 32'd3);
    chk("t5_accepts", 32'(acc_cyc.size()), 32'd4);

    // reset during COMPUTE of the first sample, then restart
    mem_a = '{16'd5, 16'd7, 16'hFFFF, 16'd0};
    pulse_a();
    repeat (2) @(negedge clk);
    chk("t6_busy", 32'(busy_a), 32'd1);
    rst = 1'b1;
    start_a = 1'b1;
    @(negedge clk);
    chk_zero_a("t6");
    rst = 1'b0;
    start_a = 1'b0;
    exp_a.push_back(8'h55);
    exp_a.push_back(8'h4F);
    pulse_a();
    chk("t6_restart_addr", 32'(addr_a), 32'd0);
    chk("t6_restart_busy", 32'(busy_a), 32'd1);
    wait_done_a(60);
    chk("t6_cnt", 32'(cnt_a), 32'd2);
    chk("t6_ovf", 32'(ovf_a), 32'd0);

    // zero-latency instance
    mem_b = '{16'd3, 16'hFFFF, 16'd0, 16'd0};
    exp_b.push_back(8'h53);
    @(negedge clk); start_b = 1'b1;
    @(negedge clk); start_b = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("t7_valid_early", 32'(valid_b), 32'd0);
    @(negedge clk);
    chk("t7_valid", 32'(valid_b), 32'd1);
    chk("t7_pout",  32'(pout_b),  32'h53);
    n = 0;
    while (!done_b && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("t7_done_wait", 32'(done_b), 32'd1);
`ifdef INF_SEQ_CYCLE_CNT_EN
    chk("t7_cycle_count", cc_b, 32'd6);
    chk("t6_cycle_count_a", 32'(cc_a == 32'd0), 32'd0);
`endif
    chk("t7_cnt",  32'(cnt_b),  32'd1);
    chk("t7_ovf",  32'(ovf_b),  32'd0);
    chk("t7_busy", 32'(busy_b), 32'd0);
    chk("t7_addr", 32'(addr_b), 32'd1);
    chk("t7_ms",   32'(ms_b),   32'd3);

    chk("a_queue_empty", 32'(exp_a.size()), 32'd0);
    chk("b_queue_empty", 32'(exp_b.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
